tdm_ingress_mux: RTL and testbench
==================================

# tdm_ingress_mux

Time-division ingress multiplexer that sits directly upstream of the 14x14 BPU top. It collects byte streams from NUM_PORTS independent ingress ports into per-port FIFOs. It then serialises them onto the single 8-bit slotted bus consumed by the BPU (`input_wire`, `input_new_packet`, `input_data`), one port per slot. Its free-running slot counter is reset together with the BPU's slot counter, so port p's byte appears exactly in the cycle the BPU's slot counter equals p.

## Interface
- DATA_WIDTH, 8, byte width per port and on the TDM bus
- NUM_PORTS, 14, number of ingress ports; slots 0..NUM_PORTS-1 are live
- FRAME_LEN, 256, slot counter modulus; must equal 2^(BPU slot counter width), ≥ NUM_PORTS
- FIFO_DEPTH, 8, entries per port FIFO (power of two, ≥ 2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  NUM_PORTS  per-port byte valid
- in_sop  in  NUM_PORTS  per-port first byte of packet, qualified by in_valid
- in_data  in  NUM_PORTS*DATA_WIDTH  port p at [p*DATA_WIDTH +: DATA_WIDTH]
- in_ready  out  NUM_PORTS  per-port FIFO not full
- tdm_valid  out  1  drives BPU `input_wire`
- tdm_new_packet  out  1  drives BPU `input_new_packet`
- tdm_data  out  DATA_WIDTH  drives BPU `input_data`
- slot  out  8  current slot counter value, for alignment checks
- byte_count  out  32  bytes emitted on the TDM bus; present only with the stats macro

## Operation
- Slot counter `slot`:
  - reset 0
  - +1 every cycle, wraps FRAME_LEN-1 → 0
  - no enable; counts while out of reset
- Per-port FIFOs:
  - entry = {sop, data}
  - push when in_valid[p] && in_ready[p]
  - in_ready[p] = !full[p], computed from registered occupancy
  - a pop in the same cycle does not make room for a same-cycle push into a full FIFO
  - bytes offered while in_ready[p]=0 are the sender's responsibility to hold
- Serialiser:
  - at each rising edge, next = (slot+1) mod FRAME_LEN
  - if next < NUM_PORTS and FIFO[next] is non-empty: pop its head and register tdm_valid=1, tdm_new_packet=sop, tdm_data=data
  - otherwise register tdm_valid=0, tdm_new_packet=0, tdm_data=0
  - result: the output during the cycle slot==k carries port k's byte
- Slots NUM_PORTS..FRAME_LEN-1 are always idle.
- At most one pop per cycle. Each port gets at most one byte per FRAME_LEN cycles.
- Simultaneous push and pop on the same port in the same cycle: both take effect, occupancy unchanged.
- Empty FIFO at its slot: idle slot, no state change.
- In-packet bytes keep FIFO order. tdm_new_packet is a pure copy of the stored sop; no framing check.

## Timing
- Reset values:
  - slot=0, tdm_valid=0, tdm_new_packet=0, tdm_data=0
  - in_ready=all ones
  - all FIFOs empty
  - byte_count=0
- First post-reset cycle (slot 0) is always idle, because the output register was reset. Port 0 is first served at slot 0 of the second frame (cycle 256).
- Latency: a byte pushed at edge E into an empty FIFO p is emitted in the cycle slot==p, at the earliest once the lookahead edge strictly after E has passed, i.e. first slot p occurring ≥2 cycles after E.
- Reset mid-operation:
  - asynchronous clear of all FIFOs, outputs and counter
  - bytes in flight are lost
  - the BPU must be reset by the same rst to keep alignment
- All outputs are registered. No combinational path from in_* to tdm_*. in_ready depends only on registered state.

## Configuration
- TDM_INGRESS_STATS_EN:
  - when defined, byte_count is present: a 32-bit counter, +1 on every cycle tdm_valid=1, wraps at 2^32, reset 0
  - when undefined, the byte_count port and its counter are absent
  - all other behaviour is identical

## Test plan
- Reset, then drive nothing for 300 cycles → tdm_valid=0 throughout; slot goes 0..255,0..43; in_ready=14'h3FFF.
- Port 3 pushes sop byte 0xA5 at cycle 10 → tdm_valid=1, tdm_new_packet=1, tdm_data=0xA5 exactly in the cycle slot==3 of frame 1 (cycle 259); all other slots idle.
- All 14 ports push one byte each (data=port index) at cycle 20 → frame 1 slots 0..13 emit 0x00..0x0D with tdm_valid=1; slots 14..255 idle.
- Port 5 pushes 9 bytes back-to-back with FIFO_DEPTH=8 → in_ready[5] drops after the 8th accept; the 9th is held until the slot-5 pop frees space; bytes 1..9 are emitted in order, one per frame.
- Port 0 full; pop and push coincide at slot 0 → push refused that cycle (in_ready[0]=0), occupancy goes 8→7, push accepted next cycle.
- Assert rst low mid-frame with 4 ports holding data → outputs 0 and slot=0 immediately; after release, no stale byte ever appears. With TDM_INGRESS_STATS_EN, byte_count=0 after reset and equals the emitted byte count.

Source files
------------

// File: rtl/tdm_ingress_mux.sv
// Time-division ingress multiplexer: per-port byte FIFOs serialised onto the BPU slotted bus.
// Optional byte counter on the TDM bus is enabled by defining TDM_INGRESS_STATS_EN.
module tdm_ingress_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 14,
    parameter int FRAME_LEN  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS-1:0]            in_sop,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic                            tdm_valid,
    output logic                            tdm_new_packet,
    output logic [DATA_WIDTH-1:0]           tdm_data,
    output logic [7:0]                      slot
`ifdef TDM_INGRESS_STATS_EN
    ,
    output logic [31:0]                     byte_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 1;

    logic [EW-1:0]         mem_r [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_r [NUM_PORTS];
    logic [AW-1:0]         wr_ptr_r [NUM_PORTS];
    logic [AW:0]           count_r [NUM_PORTS];
    logic [AW:0]           count_next_s [NUM_PORTS];
    logic [NUM_PORTS-1:0]  ready_r;
    logic [NUM_PORTS-1:0]  push_s;
    logic [NUM_PORTS-1:0]  pop_s;
    logic [EW-1:0]         head_s;
    logic [7:0]            slot_r;
    logic [7:0]            next_slot_s;
    logic                  tdm_valid_r;
    logic                  tdm_new_packet_r;
    logic [DATA_WIDTH-1:0] tdm_data_r;

    // Lookahead slot: the output register is loaded for the slot that starts after this edge.
    always_comb begin
        next_slot_s = 8'd0;
        if (slot_r == 8'(FRAME_LEN - 1)) begin
            next_slot_s = 8'd0;
        end else begin
            next_slot_s = slot_r + 8'd1;
        end
    end

    // Push/pop decisions, head selection and next occupancy per port.
    always_comb begin
        push_s = '0;
        pop_s  = '0;
        head_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            count_next_s[p] = count_r[p];
            // ready_r reflects only registered occupancy, so a same-cycle pop never frees room
            push_s[p] = in_valid[p] && ready_r[p];
            if ((next_slot_s == 8'(p)) && (count_r[p] != '0)) begin
                pop_s[p] = 1'b1;
                head_s   = mem_r[p][rd_ptr_r[p]];
            end else begin
                pop_s[p] = 1'b0;
            end
            case ({push_s[p], pop_s[p]})
                2'b10:   count_next_s[p] = count_r[p] + (AW+1)'(1);
                2'b01:   count_next_s[p] = count_r[p] - (AW+1)'(1);
                default: count_next_s[p] = count_r[p];
            endcase
        end
    end

    // FIFO storage, written on accepted pushes.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push_s[p]) begin
                mem_r[p][wr_ptr_r[p]] <= {in_sop[p], in_data[p*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // FIFO pointers, occupancy and registered ready flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_r <= '1;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_ptr_r[p] <= '0;
                wr_ptr_r[p] <= '0;
                count_r[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (push_s[p]) begin
                    wr_ptr_r[p] <= wr_ptr_r[p] + AW'(1);
                end
                if (pop_s[p]) begin
                    rd_ptr_r[p] <= rd_ptr_r[p] + AW'(1);
                end
                count_r[p] <= count_next_s[p];
                ready_r[p] <= (count_next_s[p] != (AW+1)'(FIFO_DEPTH));
            end
        end
    end

    // Slot counter and registered TDM bus; idle slots drive all zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_r           <= 8'd0;
            tdm_valid_r      <= 1'b0;
            tdm_new_packet_r <= 1'b0;
            tdm_data_r       <= '0;
        end else begin
            slot_r           <= next_slot_s;
            tdm_valid_r      <= |pop_s;
            tdm_new_packet_r <= head_s[DATA_WIDTH];
            tdm_data_r       <= head_s[DATA_WIDTH-1:0];
        end
    end

`ifdef TDM_INGRESS_STATS_EN
    logic [31:0] byte_count_r;

    // Count of bytes emitted on the TDM bus, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_count_r <= 32'd0;
        end else begin
            byte_count_r <= byte_count_r + {31'd0, tdm_valid_r};
        end
    end

    assign byte_count = byte_count_r;
`endif

    assign in_ready       = ready_r;
    assign slot           = slot_r;
    assign tdm_valid      = tdm_valid_r;
    assign tdm_new_packet = tdm_new_packet_r;
    assign tdm_data       = tdm_data_r;

endmodule

// File: tb/tb_tdm_ingress_mux.sv
// Directed self-checking bench for tdm_ingress_mux (default parameters).
module tb_tdm_ingress_mux;

    localparam int DW = 8;
    localparam int NP = 14;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NP-1:0]    in_valid = '0;
    logic [NP-1:0]    in_sop = '0;
    logic [NP*DW-1:0] in_data = '0;
    logic [NP-1:0]    in_ready;
    logic             tdm_valid;
    logic             tdm_new_packet;
    logic [DW-1:0]    tdm_data;
    logic [7:0]       slot;
`ifdef TDM_INGRESS_STATS_EN
    logic [31:0]      byte_count;
    int               exp_bc = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int idx;
    int k;
    logic exp_rdy;

    tdm_ingress_mux dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .tdm_valid      (tdm_valid),
        .tdm_new_packet (tdm_new_packet),
        .tdm_data       (tdm_data),
        .slot           (slot)
`ifdef TDM_INGRESS_STATS_EN
        ,
        .byte_count     (byte_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Compares {valid, new_packet, data, slot} for the current cycle.
    task automatic chk_bus(input logic v, input logic np, input logic [7:0] d);
        chk("bus", 32'({tdm_valid, tdm_new_packet, tdm_data, slot}),
            32'({v, np, d, 8'(cyc % 256)}));
`ifdef TDM_INGRESS_STATS_EN
        chk("byte_count", byte_count, 32'(exp_bc));
        if (v) exp_bc++;
`endif
    endtask

    task automatic next_cyc();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        in_valid = '0;
        in_sop   = '0;
        in_data  = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
`ifdef TDM_INGRESS_STATS_EN
        exp_bc = 0;
`endif
    endtask

    initial begin
        // Idle run: nothing emitted, slot wraps, all ports ready.
        do_reset();
        repeat (300) begin
            chk_bus(1'b0, 1'b0, 8'h00);
            chk("in_ready_idle", 32'(in_ready), 32'h3FFF);
            next_cyc();
        end

        // Single sop byte on port 3 at cycle 10 appears at cycle 259.
        do_reset();
        while (cyc <= 300) begin
            chk_bus(cyc == 259, cyc == 259, (cyc == 259) ? 8'hA5 : 8'h00);
            in_valid = (cyc == 10) ? 14'h0008 : 14'h0000;
            in_sop   = in_valid;
            in_data[3*DW +: DW] = 8'hA5;
            next_cyc();
        end

        // Every port pushes its own index at cycle 20.
        do_reset();
        while (cyc <= 300) begin
            if (cyc >= 256 && cyc <= 269) chk_bus(1'b1, 1'b1, 8'(cyc - 256));
            else                          chk_bus(1'b0, 1'b0, 8'h00);
            if (cyc == 20) begin
                in_valid = '1;
                in_sop   = '1;
                for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = 8'(p);
            end else begin
                in_valid = '0;
                in_sop   = '0;
            end
            next_cyc();
        end

        // Port 5 offers bytes 1..9 back-to-back into an 8-deep FIFO.
        do_reset();
        idx = 1;
        while (cyc <= 2310) begin
            k = cyc / 256;
            if ((cyc % 256 == 5) && k >= 1 && k <= 9) chk_bus(1'b1, k == 1, 8'(k));
            else                                     chk_bus(1'b0, 1'b0, 8'h00);
            exp_rdy = !((cyc >= 18 && cyc <= 260) || (cyc >= 262 && cyc <= 516));
            chk("in_ready5", 32'(in_ready[5]), 32'(exp_rdy));
            if (cyc >= 10 && idx <= 9) begin
                in_valid = 14'h0020;
                in_sop   = (idx == 1) ? 14'h0020 : 14'h0000;
                in_data[5*DW +: DW] = 8'(idx);
                if (in_ready[5]) idx++;
            end else begin
                in_valid = '0;
                in_sop   = '0;
            end
            next_cyc();
        end

        // Port 0 full when its slot-0 pop coincides with a held push.
        do_reset();
        idx = 0;
        while (cyc <= 258) begin
            if (cyc == 256) chk_bus(1'b1, 1'b1, 8'h10);
            else            chk_bus(1'b0, 1'b0, 8'h00);
            if (cyc >= 250) chk("in_ready0", 32'(in_ready[0]), 32'(cyc == 256));
            if (cyc >= 10 && idx <= 8) begin
                in_valid = 14'h0001;
                in_sop   = (idx == 0) ? 14'h0001 : 14'h0000;
                in_data[DW-1:0] = 8'(8'h10 + idx);
                if (in_ready[0]) idx++;
            end else begin
                in_valid = '0;
                in_sop   = '0;
            end
            next_cyc();
        end

        // Reset mid-frame while ports 1..4 still hold bytes.
        do_reset();
        while (cyc < 258) begin
            if (cyc == 257) chk_bus(1'b1, 1'b1, 8'h31);
            else            chk_bus(1'b0, 1'b0, 8'h00);
            if (cyc == 10 || cyc == 11) begin
                in_valid = 14'h001E;
                in_sop   = (cyc == 10) ? 14'h001E : 14'h0000;
                for (int p = 1; p <= 4; p++) in_data[p*DW +: DW] = 8'(((cyc == 10) ? 8'h30 : 8'h40) + p);
            end else begin
                in_valid = '0;
                in_sop   = '0;
            end
            next_cyc();
        end
        chk_bus(1'b1, 1'b1, 8'h32);
        rst = 1'b0;
        #1;
        chk("reset_bus", 32'({tdm_valid, tdm_new_packet, tdm_data, slot}), 32'h0);
        chk("reset_ready", 32'(in_ready), 32'h3FFF);
`ifdef TDM_INGRESS_STATS_EN
        chk("reset_byte_count", byte_count, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
`ifdef TDM_INGRESS_STATS_EN
        exp_bc = 0;
`endif
        repeat (600) begin
            chk_bus(1'b0, 1'b0, 8'h00);
            next_cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
